// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared types and constants for the load-only memory
//               controller: end-token FSM state encoding, the BRAM read
//               latency and an index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

  // End-token handshake states, 2-bit encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    DONE = 2'd2
  } memCtrlState_t;

  // BRAM presents read data one cycle after the enable/address cycle
  localparam int c_BRAM_READ_LATENCY = 1;

  // Width of a port index; at least one bit so single-port builds stay legal
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/read_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : read_memory_arbiter
// Description : Purely combinational fixed-priority arbiter. The lowest
//               index request wins; outputs one-hot grant, encoded index
//               and an any-grant flag.
// Revision    : 1.0 - initial release
// ============================================================================
module read_memory_arbiter #(
  parameter int NUM_REQ = 1,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grantIdx,
  output logic               anyGrant
);

  // Scan from the highest index down so the lowest requesting index is the last writer
  always_comb begin
    grant    = '0;
    grantIdx = '0;
    anyGrant = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        grantIdx = IDX_W'(i);
        anyGrant = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_controller_storeless.sv
`default_nettype none
// ============================================================================
// Module      : mem_controller_storeless
// Description : Load-only BRAM controller. Arbitrates NUM_LOADS load
//               channels onto one BRAM read port, returns each word to its
//               requesting port through a one-entry output slot, and emits
//               memEnd once the end token has arrived and nothing is pending.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_controller_storeless
  import mem_ctrl_pkg::*;
#(
  parameter int NUM_LOADS  = 1,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_LOADS*ADDR_WIDTH-1:0] ldAddr,
  input  logic [NUM_LOADS-1:0]            ldAddr_valid,
  output logic [NUM_LOADS-1:0]            ldAddr_ready,
  output logic [NUM_LOADS*DATA_WIDTH-1:0] ldData,
  output logic [NUM_LOADS-1:0]            ldData_valid,
  input  logic [NUM_LOADS-1:0]            ldData_ready,
  input  logic                            ctrlEnd_valid,
  output logic                            ctrlEnd_ready,
  output logic                            memEnd_valid,
  input  logic                            memEnd_ready,
  input  logic [DATA_WIDTH-1:0]           loadData,
  output logic                            loadEn,
  output logic [ADDR_WIDTH-1:0]           loadAddr,
  output logic                            storeEn,
  output logic [ADDR_WIDTH-1:0]           storeAddr,
  output logic [DATA_WIDTH-1:0]           storeData
);

  localparam int c_IDX_W = idxWidth(NUM_LOADS);

  logic [NUM_LOADS-1:0]            w_eligible;
  logic [NUM_LOADS-1:0]            w_grant;
  logic [c_IDX_W-1:0]              w_grantIdx;
  logic                            w_anyGrant;
  logic                            w_quiet;
  logic                            r_inflightV;
  logic [c_IDX_W-1:0]              r_inflightIdx;
  logic [NUM_LOADS-1:0]            r_dataValid;
  logic [NUM_LOADS*DATA_WIDTH-1:0] r_data;
  memCtrlState_t                   r_state;
  memCtrlState_t                   w_nextState;

  // A port may issue when its slot frees this cycle and it has no read in the BRAM pipe
  for (genvar i = 0; i < NUM_LOADS; i++) begin : g_elig
    assign w_eligible[i] = ldAddr_valid[i]
                         & (~r_dataValid[i] | ldData_ready[i])
                         & ~(r_inflightV & (r_inflightIdx == c_IDX_W'(i)));
  end

  read_memory_arbiter #(
    .NUM_REQ (NUM_LOADS),
    .IDX_W   (c_IDX_W)
  ) u_arbiter (
    .req      (w_eligible),
    .grant    (w_grant),
    .grantIdx (w_grantIdx),
    .anyGrant (w_anyGrant)
  );

  assign ldAddr_ready = w_grant;
  assign loadEn       = w_anyGrant;

  // One-hot AND-OR mux of the granted address; zero when nothing is granted
  always_comb begin
    loadAddr = '0;
    for (int i = 0; i < NUM_LOADS; i++) begin
      if (w_grant[i]) begin
        loadAddr = loadAddr | ldAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign storeEn   = 1'b0;
  assign storeAddr = '0;
  assign storeData = '0;

  // Track which port owns the word the BRAM returns next cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_inflightV   <= 1'b0;
      r_inflightIdx <= '0;
    end else begin
      r_inflightV <= w_anyGrant;
      if (w_anyGrant) begin
        r_inflightIdx <= w_grantIdx;
      end
    end
  end

  // Per-port output slots: a returning word beats a same-cycle drain
  for (genvar i = 0; i < NUM_LOADS; i++) begin : g_slot
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_dataValid[i]                       <= 1'b0;
        r_data[i*DATA_WIDTH +: DATA_WIDTH]   <= '0;
      end else if (r_inflightV && (r_inflightIdx == c_IDX_W'(i))) begin
        r_dataValid[i]                       <= 1'b1;
        r_data[i*DATA_WIDTH +: DATA_WIDTH]   <= loadData;
      end else if (ldData_ready[i]) begin
        r_dataValid[i]                       <= 1'b0;
      end
    end
  end

  assign ldData       = r_data;
  assign ldData_valid = r_dataValid;

  // No read in flight, nothing buffered and nothing requesting
  assign w_quiet = ~r_inflightV & ~(|r_dataValid) & ~(|ldAddr_valid);

  // End-token FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // End-token FSM next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (ctrlEnd_valid) w_nextState = PEND;
      PEND:    if (w_quiet)       w_nextState = DONE;
      DONE:    if (memEnd_ready)  w_nextState = IDLE;
      default:                    w_nextState = IDLE;
    endcase
  end

  // End-token FSM outputs
  always_comb begin
    ctrlEnd_ready = (r_state == IDLE);
    memEnd_valid  = (r_state == DONE);
  end

endmodule
`default_nettype wire
